// File: rtl/counter_pkg.sv
// Shared constants and helpers for the pushbutton up/down counter.
// Imported by the conditioner and the counter top level.
package counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b1;
   localparam logic MODE_SAT  = 1'b0;

   function automatic int deb_cnt_w(input int deb_cycles);
      return $clog2(deb_cycles + 1);
   endfunction

endpackage

// File: rtl/pb_conditioner.sv
// Pushbutton conditioning: 2-flop sync, debounce, and a registered
// one-cycle step pulse on each debounced press (1->0).
module pb_conditioner
   import counter_pkg::*;
#(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic pb,
   output logic step
);

   localparam int CW = deb_cnt_w(DEB_CYCLES);
   localparam logic [CW-1:0] CLAST = CW'(DEB_CYCLES - 1);

   logic          s1, s2;
   logic          deb;
   logic          deb_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= pb;
         s2 <= s1;
      end
   end

   // Level flips only after DEB_CYCLES back-to-back mismatches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb <= 1'b1;
         cnt <= '0;
      end else if (s2 != deb) begin
         if (cnt == CLAST) begin
            deb <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_q <= 1'b1;
         step  <= 1'b0;
      end else begin
         deb_q <= deb;
         step  <= deb_q & ~deb;
      end
   end

endmodule

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts immediately, releases two clk edges
// after the external active-low reset is removed.
module rst_sync (
   input  logic clk,
   input  logic rst,
   output logic rst_s
);

   logic [1:0] ff;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ff <= 2'b00;
      else      ff <= {ff[0], 1'b1};
   end

   assign rst_s = ff[1];

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter stepped by a debounced pushbutton, with load,
// wrap/saturate mode, terminal-count pulse and limit flags.
module updown_counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH      = 7,
   parameter int MAX_VAL    = 99,
   parameter int DEB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pb,
   input  logic             en,
   input  logic             dir,
   input  logic             wrap,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_max,
   output logic             at_min
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

   logic             rst_s;
   logic             step;
   logic [WIDTH-1:0] nxt;
   logic             wrp;

   rst_sync u_rst (
      .clk   (clk),
      .rst   (rst),
      .rst_s (rst_s)
   );

   pb_conditioner #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_pb (
      .clk  (clk),
      .rst  (rst_s),
      .pb   (pb),
      .step (step)
   );

   always_comb begin
      nxt = count;
      wrp = 1'b0;
      if (load) begin
         nxt = (load_val > MAXV) ? MAXV : load_val;
      end else if (step && en) begin
         if (dir == DIR_UP) begin
            if (count < MAXV) begin
               nxt = count + WIDTH'(1);
            end else if (wrap == MODE_WRAP) begin
               nxt = '0;
               wrp = 1'b1;
            end
         end else begin
            if (count != '0) begin
               nxt = count - WIDTH'(1);
            end else if (wrap == MODE_WRAP) begin
               nxt = MAXV;
               wrp = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         count <= '0;
         tc    <= 1'b0;
      end else begin
         count <= nxt;
         tc    <= wrp;
      end
   end

   assign at_max = (count == MAXV);
   assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod (WIDTH=7, MAX_VAL=99,
// DEB_CYCLES=4): vector table plus hand-written timing sequences.
module tb_updown_counter_mod;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pb = 1'b1;
   logic       en = 1'b1;
   logic       dir = 1'b1;
   logic       wrap = 1'b1;
   logic       load = 1'b0;
   logic [6:0] load_val = '0;
   logic [6:0] count;
   logic       tc;
   logic       at_max;
   logic       at_min;

   int checks = 0;
   int fails = 0;
   int pulses;

   updown_counter_mod #(
      .WIDTH      (7),
      .MAX_VAL    (99),
      .DEB_CYCLES (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pb       (pb),
      .en       (en),
      .dir      (dir),
      .wrap     (wrap),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .tc       (tc),
      .at_max   (at_max),
      .at_min   (at_min)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic [6:0] lv;
      logic       prs;
      logic       d;
      logic       w;
      logic       e;
      int         exp_cnt;
      int         exp_tc;
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (tc) pulses++;
      end
   endtask

   task automatic press();
      @(negedge clk);
      pb = 1'b0;
      idle(14);
      pb = 1'b1;
      idle(14);
   endtask

   initial begin
      vt[0]  = '{1'b1, 7'd0,   1'b0, 1'b1, 1'b1, 1'b1, 0,  0};
      vt[1]  = '{1'b0, 7'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1,  0};
      vt[2]  = '{1'b0, 7'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1,  0};
      vt[3]  = '{1'b1, 7'd99,  1'b0, 1'b1, 1'b1, 1'b1, 99, 0};
      vt[4]  = '{1'b0, 7'd0,   1'b1, 1'b1, 1'b1, 1'b1, 0,  1};
      vt[5]  = '{1'b1, 7'd99,  1'b0, 1'b1, 1'b0, 1'b1, 99, 0};
      vt[6]  = '{1'b0, 7'd0,   1'b1, 1'b1, 1'b0, 1'b1, 99, 0};
      vt[7]  = '{1'b0, 7'd0,   1'b1, 1'b0, 1'b0, 1'b1, 98, 0};
      vt[8]  = '{1'b1, 7'd0,   1'b0, 1'b0, 1'b1, 1'b1, 0,  0};
      vt[9]  = '{1'b0, 7'd0,   1'b1, 1'b0, 1'b1, 1'b1, 99, 1};
      vt[10] = '{1'b1, 7'd0,   1'b0, 1'b0, 1'b0, 1'b1, 0,  0};
      vt[11] = '{1'b0, 7'd0,   1'b1, 1'b0, 1'b0, 1'b1, 0,  0};
      vt[12] = '{1'b1, 7'd120, 1'b0, 1'b1, 1'b1, 1'b1, 99, 0};
      vt[13] = '{1'b1, 7'd50,  1'b0, 1'b1, 1'b1, 1'b1, 50, 0};
      vt[14] = '{1'b0, 7'd0,   1'b1, 1'b1, 1'b0, 1'b1, 51, 0};
      vt[15] = '{1'b1, 7'd127, 1'b0, 1'b0, 1'b0, 1'b1, 99, 0};

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_count", int'(count), 0);
      chk("rst_tc", int'(tc), 0);
      chk("rst_at_min", int'(at_min), 1);
      chk("rst_at_max", int'(at_max), 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // press latency: 8 edges from pb fall to count change
      pb = 1'b0;
      repeat (7) @(negedge clk);
      chk("lat_before", int'(count), 0);
      @(negedge clk);
      chk("lat_at", int'(count), 1);
      pb = 1'b1;
      repeat (15) @(negedge clk);
      chk("release_hold", int'(count), 1);

      // bounce 2 low / 2 high, then held low: one step only
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         pb = (i % 2 == 0) ? 1'b0 : 1'b1;
         idle(2);
      end
      chk("bounce_mid", int'(count), 1);
      pb = 1'b0;
      idle(14);
      pb = 1'b1;
      idle(14);
      chk("bounce_cnt", int'(count), 2);
      chk("bounce_tc", pulses, 0);

      // vector table
      for (int k = 0; k < 16; k++) begin
         pulses = 0;
         dir  = vt[k].d;
         wrap = vt[k].w;
         en   = vt[k].e;
         if (vt[k].ld) begin
            @(negedge clk);
            load = 1'b1;
            load_val = vt[k].lv;
            @(negedge clk);
            load = 1'b0;
            if (tc) pulses++;
         end
         if (vt[k].prs) press();
         @(negedge clk);
         chk($sformatf("v%0d_count", k), int'(count), vt[k].exp_cnt);
         chk($sformatf("v%0d_tc", k), pulses, vt[k].exp_tc);
         chk($sformatf("v%0d_max", k), int'(at_max),
             (vt[k].exp_cnt == 99) ? 1 : 0);
         chk($sformatf("v%0d_min", k), int'(at_min),
             (vt[k].exp_cnt == 0) ? 1 : 0);
      end

      // load coincident with the step cycle: load wins
      en = 1'b1;
      dir = 1'b1;
      wrap = 1'b1;
      @(negedge clk);
      load = 1'b1;
      load_val = 7'd10;
      @(negedge clk);
      load = 1'b0;
      pb = 1'b0;
      repeat (7) @(negedge clk);
      load = 1'b1;
      load_val = 7'd30;
      @(negedge clk);
      load = 1'b0;
      chk("coinc_load", int'(count), 30);
      pb = 1'b1;
      repeat (15) @(negedge clk);
      chk("coinc_after", int'(count), 30);

      // reset two cycles into the debounce window
      pb = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("async_rst", int'(count), 0);
      repeat (2) @(negedge clk);
      pb = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      idle(20);
      chk("midrst_count", int'(count), 0);
      chk("midrst_tc", pulses, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/updown_counter_mod.md
UPDOWN_COUNTER_MOD -- requirements
Module: updown_counter_mod

Interface
REQ-001 Parameter WIDTH, default 7: count width in bits; legal range 2..16.
REQ-002 Parameter MAX_VAL, default 99: highest count value; legal range 1..2^WIDTH-1.
REQ-003 Parameter DEB_CYCLES, default 16: consecutive stable samples needed to accept a pb level change; minimum 1.
REQ-004 Port clk, input, 1: system clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-low.
REQ-006 Port pb, input, 1: raw pushbutton, asynchronous to clk, active-low (pressed = 0).
REQ-007 Port en, input, 1: synchronous count enable; when 0, step events are discarded.
REQ-008 Port dir, input, 1: 1 = count up, 0 = count down; sampled on the cycle the step is applied.
REQ-009 Port wrap, input, 1: 1 = modulo (MAX_VAL+1) wrap, 0 = saturate at the limits.
REQ-010 Port load, input, 1: synchronous load strobe.
REQ-011 Port load_val, input, WIDTH: value loaded when load = 1.
REQ-012 Port count, output, WIDTH: registered count value.
REQ-013 Port tc, output, 1: one-cycle pulse on the cycle after a wrap occurs (MAX_VAL->0 up, or 0->MAX_VAL down).
REQ-014 Port at_max / at_min, output, 1 each: combinational flags, count == MAX_VAL and count == 0 respectively.

Function
REQ-015 pb SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 The debounced level SHALL change only after the synchronized pb differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle SHALL clear the stability counter.
REQ-017 A 1->0 transition of the debounced level SHALL produce a single-cycle step pulse; a release (0->1) SHALL produce none.
REQ-018 Latency from a clean pb fall to the count change SHALL be exactly 2 (sync) + DEB_CYCLES + 1 (edge) + 1 (update) clk cycles.
REQ-019 Update priority SHALL be: rst > load > (step & en) > hold.
REQ-020 On load, count SHALL become load_val if load_val <= MAX_VAL, else MAX_VAL; tc SHALL NOT assert on a load.
REQ-021 Step while counting up with count < MAX_VAL SHALL set count+1; with count == MAX_VAL, it SHALL set 0 if wrap = 1, else hold.
REQ-022 Step while counting down with count > 0 SHALL set count-1; with count == 0, it SHALL set MAX_VAL if wrap = 1, else hold.
REQ-023 tc SHALL assert for exactly one cycle only on the wrap transitions in REQ-021/REQ-022; saturation holds SHALL NOT assert tc.
REQ-024 Arithmetic SHALL be WIDTH bits with no intermediate overflow; count SHALL never exceed MAX_VAL.
REQ-025 A step arriving while en = 0 SHALL be lost, not queued.
REQ-026 A step coincident with load SHALL be discarded.

Reset
REQ-027 On rst assertion the block SHALL immediately force: count = 0, tc = 0, synchronizer flops = 1, debounced level = 1 (released), stability counter = 0, edge register = 1.
REQ-028 Reset asserted mid-debounce SHALL abandon the pending press; no step SHALL be generated from it after rst is released.
REQ-029 Deassertion of rst SHALL be synchronized to clk before it releases the state.

Structure
REQ-030 Shared package counter_pkg SHALL hold the DIR_UP/DIR_DOWN and MODE_WRAP/MODE_SAT constants and a function that computes the stability-counter width, clog2(DEB_CYCLES+1).
REQ-031 Synchronizer, debouncer and falling-edge detector SHALL form one sub-module, pb_conditioner(clk, rst, pb, step).
REQ-032 The top level SHALL contain only the count register, next-value logic, tc register and flags.

Verification (WIDTH=7, MAX_VAL=99, DEB_CYCLES=4)
REQ-033 Reset, then one clean press with en=1, dir=1 -> count 0->1 exactly 8 cycles after the pb fall; release gives no further change.
REQ-034 pb bouncing 0/1 every 2 cycles for 20 cycles, then held low -> exactly one increment.
REQ-035 load=1, load_val=99, then a press with dir=1, wrap=1 -> count=0 and tc high for one cycle; the same with wrap=0 -> count stays 99 and tc stays low.
REQ-036 count=0, dir=0: press with wrap=1 -> 99 with tc pulse; press with wrap=0 -> 0 held.
REQ-037 load_val=120 -> count=99; load coincident with step -> count equals the clamped load_val only.
REQ-038 rst asserted 2 cycles into a debounce window, then released -> count=0 and no step is generated.
